// File: rtl/detector_jogada_if.sv
// Button/play bundle between the raw player buttons, the control unit and
// the detector. The detector sits on the slave side; whoever drives the
// buttons and the enable and consumes the play takes the master side.
interface detector_jogada_if #(
    parameter int N_BOTOES = 4
);
    logic [N_BOTOES-1:0] botoes;
    logic                habilita;
    logic                jogada;
    logic [N_BOTOES-1:0] jogada_code;
    logic                multipla;
    logic [1:0]          db_estado;

    modport master (
        output botoes,
        output habilita,
        input  jogada,
        input  jogada_code,
        input  multipla,
        input  db_estado
    );

    modport slave (
        input  botoes,
        input  habilita,
        output jogada,
        output jogada_code,
        output multipla,
        output db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// Play detector: synchronises and debounces the raw buttons and emits a
// single-cycle jogada pulse per confirmed press, with the registered button
// code and a multi-button flag. A full debounced release is required before
// the next press can be accepted, so held buttons never re-trigger.
module detector_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic              clock,
    input  logic              reset,
    detector_jogada_if.slave  bus
);
    // Counter just wide enough to reach DEBOUNCE_CICLOS-1 (DEBOUNCE_CICLOS >= 2).
    localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        FILTRA = 2'd1,
        PULSO  = 2'd2,
        SOLTA  = 2'd3
    } estado_t;

    estado_t             state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [N_BOTOES-1:0] cand_reg, cand_next;
    logic [N_BOTOES-1:0] code_reg, code_next;
    logic                mult_reg, mult_next;
    logic                jogada_comb;

    logic [N_BOTOES-1:0] sync_a_reg;
    logic [N_BOTOES-1:0] b_sync;
    logic                cand_multi;

    // Two-flop synchroniser, one independent chain per button.
    generate
        for (genvar gi = 0; gi < N_BOTOES; gi++) begin : g_sync
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_a_reg[gi] <= 1'b0;
                    b_sync[gi]     <= 1'b0;
                end else begin
                    sync_a_reg[gi] <= bus.botoes[gi];
                    b_sync[gi]     <= sync_a_reg[gi];
                end
            end
        end
    endgenerate

    // More than one bit set: clearing the lowest set bit leaves something.
    assign cand_multi = (cand_reg & (cand_reg - 1'b1)) != '0;

    // State, counter, candidate and play-output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= OCIOSO;
            cnt_reg   <= '0;
            cand_reg  <= '0;
            code_reg  <= '0;
            mult_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            code_reg  <= code_next;
            mult_reg  <= mult_next;
        end
    end

    // Next-state and datapath decisions; jogada is Moore-plus-enable in PULSO.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cand_next   = cand_reg;
        code_next   = code_reg;
        mult_next   = mult_reg;
        jogada_comb = 1'b0;
        case (state_reg)
            OCIOSO: begin
                if (b_sync != '0) begin
                    cand_next  = b_sync;
                    cnt_next   = '0;
                    state_next = FILTRA;
                end
            end
            FILTRA: begin
                // Any change of pattern (release or extra button) restarts from idle.
                if (b_sync != cand_reg) begin
                    state_next = OCIOSO;
                end else if (cnt_reg == CNT_MAX) begin
                    code_next  = cand_reg;
                    mult_next  = cand_multi;
                    state_next = PULSO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            PULSO: begin
                // Outside the enable window the press is consumed silently.
                jogada_comb = bus.habilita;
                cnt_next    = '0;
                state_next  = SOLTA;
            end
            SOLTA: begin
                // Any non-zero sample (held or bouncing) restarts the release count.
                if (b_sync != '0) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = OCIOSO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = OCIOSO;
            end
        endcase
    end

    assign bus.jogada      = jogada_comb;
    assign bus.jogada_code = code_reg;
    assign bus.multipla    = mult_reg;
    assign bus.db_estado   = state_reg;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada with DEBOUNCE_CICLOS = 4. Inputs change 1 time
// unit after a rising edge, outputs are sampled there too, and pulses are
// counted on the falling edge. A press applied when the edge counter reads k
// is first sampled at edge k+1, so jogada is seen in the cycle numbered k+7.
module tb_detector_jogada;
    localparam int NB  = 4;
    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic clock = 1'b0;
    logic reset;

    detector_jogada_if #(.N_BOTOES(NB)) bus ();

    detector_jogada #(
        .N_BOTOES(NB),
        .DEBOUNCE_CICLOS(DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int cyc        = 0;
    int pulses     = 0;
    int last_pulse = -1;
    int errors     = 0;
    int checks     = 0;

    // Edge counter.
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, away from the active edge.
    always @(negedge clock) begin
        if (bus.jogada === 1'b1) begin
            pulses     <= pulses + 1;
            last_pulse <= cyc;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NB-1:0] pat;
        logic          hab;
        int            hold;
        int            exp_pulses;
        logic [NB-1:0] exp_code;
        logic          exp_mult;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int k;
        int base;

        // Press table: pattern, enable, cycles held, then expected outcome.
        vecs[0] = '{4'b0100, 1'b1, 20, 1, 4'b0100, 1'b0}; // clean long press, no retrigger
        vecs[1] = '{4'b0011, 1'b1, 10, 1, 4'b0011, 1'b1}; // two buttons
        vecs[2] = '{4'b1000, 1'b0, 10, 0, 4'b1000, 1'b0}; // disabled: code still updates
        vecs[3] = '{4'b1000, 1'b1, 10, 1, 4'b1000, 1'b0}; // re-press enabled
        vecs[4] = '{4'b0001, 1'b1,  3, 0, 4'b1000, 1'b0}; // glitch, code unchanged
        vecs[5] = '{4'b1111, 1'b1,  8, 1, 4'b1111, 1'b1};
        vecs[6] = '{4'b0010, 1'b1,  5, 1, 4'b0010, 1'b0}; // shortest accepted hold
        vecs[7] = '{4'b0100, 1'b1,  4, 0, 4'b0010, 1'b0}; // one cycle short: rejected

        // Reset held with a button pressed.
        reset        = 1'b0;
        bus.botoes   = 4'b0010;
        bus.habilita = 1'b1;
        tick(3);
        chk("reset_jogada", int'(bus.jogada), 0);
        chk("reset_code", int'(bus.jogada_code), 0);
        chk("reset_mult", int'(bus.multipla), 0);
        chk("reset_estado", int'(bus.db_estado), 0);
        base = pulses;
        k = cyc;
        reset = 1'b1;
        tick(12);
        chk("rel_reset_pulses", pulses - base, 1);
        chk("rel_reset_latency", last_pulse - k, LAT);
        chk("rel_reset_code", int'(bus.jogada_code), 4'b0010);
        chk("held_estado", int'(bus.db_estado), 3);
        bus.botoes = '0;
        tick(12);
        chk("release_estado", int'(bus.db_estado), 0);

        // Table-driven presses.
        for (int v = 0; v < 8; v++) begin
            base = pulses;
            bus.habilita = vecs[v].hab;
            bus.botoes   = vecs[v].pat;
            k = cyc;
            tick(vecs[v].hold);
            bus.botoes = '0;
            tick(12);
            $display("vec %0d: pat=%b hab=%b hold=%0d pulses=%0d code=%b mult=%b",
                     v, vecs[v].pat, vecs[v].hab, vecs[v].hold, pulses - base,
                     bus.jogada_code, bus.multipla);
            chk($sformatf("vec%0d_pulses", v), pulses - base, vecs[v].exp_pulses);
            chk($sformatf("vec%0d_code", v), int'(bus.jogada_code), int'(vecs[v].exp_code));
            chk($sformatf("vec%0d_mult", v), int'(bus.multipla), int'(vecs[v].exp_mult));
            chk($sformatf("vec%0d_idle", v), int'(bus.db_estado), 0);
            if (vecs[v].exp_pulses == 1)
                chk($sformatf("vec%0d_latency", v), last_pulse - k, LAT);
        end
        bus.habilita = 1'b1;

        // Bounce on press: 2 cycles high / 2 low, final stable level starts at i=8.
        base = pulses;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            bus.botoes = ((i % 4) < 2) ? 4'b0001 : 4'b0000;
            if (i == 8) k = cyc;
            tick(1);
        end
        tick(14);
        chk("bounce_pulses", pulses - base, 1);
        chk("bounce_latency", last_pulse - k, LAT);
        chk("bounce_code", int'(bus.jogada_code), 4'b0001);
        // Bounce on release.
        for (int i = 0; i < 10; i++) begin
            bus.botoes = ((i % 4) < 2) ? 4'b0000 : 4'b0001;
            tick(1);
        end
        bus.botoes = '0;
        tick(12);
        chk("bounce_release_pulses", pulses - base, 1);
        chk("bounce_release_estado", int'(bus.db_estado), 0);
        $display("bounce: pulses=%0d code=%b", pulses - base, bus.jogada_code);

        // Reset in FILTRA with cnt = 2 (FILTRA entered at k+3).
        base = pulses;
        bus.botoes = 4'b0100;
        k = cyc;
        tick(5);
        chk("midfiltra_estado", int'(bus.db_estado), 1);
        reset = 1'b0;
        #1;
        chk("midfiltra_rst_jogada", int'(bus.jogada), 0);
        chk("midfiltra_rst_estado", int'(bus.db_estado), 0);
        chk("midfiltra_rst_code", int'(bus.jogada_code), 0);
        tick(2);
        k = cyc;
        reset = 1'b1;
        tick(12);
        chk("midfiltra_restart_pulses", pulses - base, 1);
        chk("midfiltra_restart_latency", last_pulse - k, LAT);
        chk("midfiltra_restart_code", int'(bus.jogada_code), 4'b0100);
        bus.botoes = '0;
        tick(12);
        $display("reset in FILTRA: pulses=%0d code=%b", pulses - base, bus.jogada_code);

        // Reset while in PULSO: pulse suppressed immediately.
        base = pulses;
        bus.botoes = 4'b0011;
        k = cyc;
        tick(LAT);
        chk("pulso_estado", int'(bus.db_estado), 2);
        chk("pulso_jogada", int'(bus.jogada), 1);
        chk("pulso_mult", int'(bus.multipla), 1);
        reset = 1'b0;
        #1;
        chk("pulso_rst_jogada", int'(bus.jogada), 0);
        chk("pulso_rst_estado", int'(bus.db_estado), 0);
        chk("pulso_rst_code", int'(bus.jogada_code), 0);
        chk("pulso_rst_mult", int'(bus.multipla), 0);
        bus.botoes = '0;
        tick(2);
        reset = 1'b1;
        tick(12);
        chk("pulso_rst_pulses", pulses - base, 0);
        chk("pulso_rst_idle", int'(bus.db_estado), 0);
        $display("reset in PULSO: pulses=%0d", pulses - base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
